// File: rtl/il_pkg.sv
// Shared definitions for the interleaver frame scheduler: FSM encoding and
// the interleaver geometry constants.
package il_pkg;

    localparam int IL_MAX_LEN = 2712;
    localparam int IL_ROW_W   = 8;
    localparam int IL_LEN_W   = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARB   = 2'd1,
        LOAD  = 2'd2,
        DRAIN = 2'd3
    } il_state_t;

endpackage

// File: rtl/il_len_check.sv
// Combinational frame-length legality test: a length is legal when it is
// non-zero, a whole number of interleaver rows and fits the interleaver memory.
module il_len_check
    import il_pkg::*;
#(
    parameter int MAX_LEN = IL_MAX_LEN,
    parameter int ROW_W   = IL_ROW_W
) (
    input  logic [IL_LEN_W-1:0] len,
    output logic                ok
);

    localparam logic [IL_LEN_W-1:0] MAX_L = IL_LEN_W'(MAX_LEN);
    localparam logic [IL_LEN_W-1:0] ROW_L = IL_LEN_W'(ROW_W);

    // Legal = non-zero, row-aligned and within the memory depth.
    always_comb begin
        ok = (len != '0) && ((len % ROW_L) == '0) && (len <= MAX_L);
    end

endmodule

// File: rtl/interleaver_frame_scheduler.sv
// Shares one interleaver between two byte-stream requesters, one frame at a
// time. Round-robin arbitration, length check, byte mux into the interleaver,
// drain counting with a watchdog, and completion/error pulses.
//
// Source handshake: a byte on src_data{i} is transferred on a rising clk edge
// exactly when src_valid[i] and src_ready[i] are both high; src_ready is only
// ever raised for the granted requester while the frame still needs bytes, and
// src_valid without grant is simply ignored.
module interleaver_frame_scheduler
    import il_pkg::*;
#(
    parameter int MAX_LEN       = IL_MAX_LEN,
    parameter int ROW_W         = IL_ROW_W,
    parameter int DRAIN_TIMEOUT = 4095
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          req,
    input  logic [IL_LEN_W-1:0] len0,
    input  logic [IL_LEN_W-1:0] len1,
    input  logic [7:0]          src_data0,
    input  logic [7:0]          src_data1,
    input  logic [1:0]          src_valid,
    output logic [1:0]          src_ready,
    output logic [1:0]          grant,
    output logic [IL_LEN_W-1:0] il_length,
    output logic [7:0]          il_data,
    output logic                il_valid,
    input  logic                il_out_valid,
    output logic [1:0]          frame_done,
    output logic [1:0]          len_err,
    output logic                timeout,
    output logic                busy,
    output il_state_t           state_dbg
);

    localparam logic [IL_LEN_W-1:0] TIMEOUT_L = IL_LEN_W'(DRAIN_TIMEOUT);

    il_state_t           state, state_d;
    logic                rr_ptr, rr_ptr_d;
    logic                owner, owner_d;
    logic [IL_LEN_W-1:0] wr_cnt, wr_cnt_d;
    logic [IL_LEN_W-1:0] rd_cnt, rd_cnt_d;
    logic [IL_LEN_W-1:0] wdog, wdog_d;
    logic [IL_LEN_W-1:0] len_d;
    logic [1:0]          grant_d, src_ready_d, frame_done_d, len_err_d;
    logic [7:0]          il_data_d;
    logic                il_valid_d, timeout_d, busy_d;

    logic                pick;
    logic [1:0]          pick_oh;
    logic [IL_LEN_W-1:0] pick_len;
    logic                len_ok;
    logic                accept;

    assign state_dbg = state;

    // Round-robin choice: the pointed-to requester if asking, else the other.
    always_comb begin
        pick     = req[rr_ptr] ? rr_ptr : ~rr_ptr;
        pick_oh  = pick ? 2'b10 : 2'b01;
        pick_len = pick ? len1 : len0;
        accept   = |(src_valid & src_ready);
    end

    il_len_check #(
        .MAX_LEN (MAX_LEN),
        .ROW_W   (ROW_W)
    ) u_len_check (
        .len (pick_len),
        .ok  (len_ok)
    );

    // Next-state and next-output logic; pulses default low every cycle.
    always_comb begin
        state_d      = state;
        rr_ptr_d     = rr_ptr;
        owner_d      = owner;
        wr_cnt_d     = wr_cnt;
        rd_cnt_d     = rd_cnt;
        wdog_d       = wdog;
        len_d        = il_length;
        grant_d      = grant;
        src_ready_d  = src_ready;
        il_data_d    = il_data;
        il_valid_d   = 1'b0;
        frame_done_d = 2'b00;
        len_err_d    = 2'b00;
        timeout_d    = 1'b0;
        case (state)
            IDLE: begin
                if (req != 2'b00) state_d = ARB;
            end
            ARB: begin
                if (!req[pick]) begin
                    state_d = IDLE;
                end else if (!len_ok) begin
                    len_err_d = pick_oh;
                    rr_ptr_d  = ~rr_ptr;
                    state_d   = IDLE;
                end else begin
                    grant_d     = pick_oh;
                    owner_d     = pick;
                    len_d       = pick_len;
                    wr_cnt_d    = '0;
                    src_ready_d = pick_oh;
                    state_d     = LOAD;
                end
            end
            LOAD: begin
                if (accept) begin
                    il_data_d  = owner ? src_data1 : src_data0;
                    il_valid_d = 1'b1;
                    wr_cnt_d   = wr_cnt + 12'd1;
                    if (wr_cnt == il_length - 12'd1) begin
                        src_ready_d = 2'b00;
                        rd_cnt_d    = '0;
                        wdog_d      = '0;
                        state_d     = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (il_out_valid) begin
                    rd_cnt_d = rd_cnt + 12'd1;
                    wdog_d   = '0;
                    if (rd_cnt_d == il_length) begin
                        frame_done_d = grant;
                        grant_d      = 2'b00;
                        rr_ptr_d     = ~rr_ptr;
                        state_d      = IDLE;
                    end
                end else begin
                    wdog_d = wdog + 12'd1;
                    if (wdog_d == TIMEOUT_L) begin
                        timeout_d = 1'b1;
                        grant_d   = 2'b00;
                        rr_ptr_d  = ~rr_ptr;
                        state_d   = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State, counters and all registered outputs; reset clears everything.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            rr_ptr     <= 1'b0;
            owner      <= 1'b0;
            wr_cnt     <= '0;
            rd_cnt     <= '0;
            wdog       <= '0;
            il_length  <= '0;
            grant      <= 2'b00;
            src_ready  <= 2'b00;
            il_data    <= 8'h00;
            il_valid   <= 1'b0;
            frame_done <= 2'b00;
            len_err    <= 2'b00;
            timeout    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_d;
            rr_ptr     <= rr_ptr_d;
            owner      <= owner_d;
            wr_cnt     <= wr_cnt_d;
            rd_cnt     <= rd_cnt_d;
            wdog       <= wdog_d;
            il_length  <= len_d;
            grant      <= grant_d;
            src_ready  <= src_ready_d;
            il_data    <= il_data_d;
            il_valid   <= il_valid_d;
            frame_done <= frame_done_d;
            len_err    <= len_err_d;
            timeout    <= timeout_d;
            busy       <= busy_d;
        end
    end

endmodule

// File: tb/tb_interleaver_frame_scheduler.sv
// Bench for interleaver_frame_scheduler. The interleaver is stood in for by
// the bench driving il_out_valid during DRAIN.
module tb_interleaver_frame_scheduler;
    import il_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req;
    logic [11:0] len0, len1;
    logic [7:0]  src_data0, src_data1;
    logic [1:0]  src_valid;
    logic [1:0]  src_ready;
    logic [1:0]  grant;
    logic [11:0] il_length;
    logic [7:0]  il_data;
    logic        il_valid;
    logic        il_out_valid;
    logic [1:0]  frame_done, len_err;
    logic        timeout, busy;
    il_state_t   state_dbg;

    int tests_run = 0;
    int failures  = 0;

    logic [7:0] exp_q[$];
    int         n_il_valid, n_done_cyc, n_err_cyc, n_to_cyc;
    logic [1:0] last_done, last_err, grant_or;
    logic       model_rr;

    interleaver_frame_scheduler #(.DRAIN_TIMEOUT(20)) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .len0         (len0),
        .len1         (len1),
        .src_data0    (src_data0),
        .src_data1    (src_data1),
        .src_valid    (src_valid),
        .src_ready    (src_ready),
        .grant        (grant),
        .il_length    (il_length),
        .il_data      (il_data),
        .il_valid     (il_valid),
        .il_out_valid (il_out_valid),
        .frame_done   (frame_done),
        .len_err      (len_err),
        .timeout      (timeout),
        .busy         (busy),
        .state_dbg    (state_dbg)
    );

    // Clock
    initial forever #5 clk = ~clk;

    // Hard stop in case something hangs outside the bounded loops
    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    task automatic clear_stats();
        n_il_valid = 0; n_done_cyc = 0; n_err_cyc = 0; n_to_cyc = 0;
        last_done = 2'b00; last_err = 2'b00; grant_or = 2'b00;
    endtask

    // One clock; sample outputs 1ns after the edge and run the scoreboard.
    task automatic tick();
        logic [7:0] e;
        @(posedge clk);
        #1;
        if (il_valid) begin
            n_il_valid++;
            tests_run++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected: il_data=%h with empty expected queue", il_data);
            end else begin
                e = exp_q.pop_front();
                if (il_data !== e) begin
                    failures++;
                    $display("FAIL sb_data: il_data=%h expected=%h", il_data, e);
                end
            end
        end
        if (frame_done != 2'b00) begin n_done_cyc++; last_done = frame_done; end
        if (len_err != 2'b00) begin n_err_cyc++; last_err = len_err; end
        if (timeout) n_to_cyc++;
        grant_or = grant_or | grant;
    endtask

    // Wait for grant of 'who', load up to n bytes (stop early at stop_at),
    // then optionally drain with il_out_valid held high for n cycles.
    task automatic run_frame(input int who, input int n, input bit gappy,
                             input bit drain, input bit keep_req, input int stop_at);
        int budget;
        int k;
        int cyc;
        logic [1:0] exp_g;
        logic [7:0] d;
        exp_g = 2'(1 << who);
        budget = 0;
        while (grant == 2'b00 && budget < 20) begin tick(); budget++; end
        tests_run++;
        if (grant !== exp_g) begin
            failures++;
            $display("FAIL grant_owner: grant=%b expected=%b", grant, exp_g);
        end
        tests_run++;
        if (il_length !== 12'(n)) begin
            failures++;
            $display("FAIL il_length: il_length=%0d expected=%0d", il_length, n);
        end
        if (!keep_req) req[who] = 1'b0;
        k = 0; cyc = 0;
        while (k < n && k < stop_at && cyc < 400) begin
            src_valid[who] = gappy ? cyc[0] : 1'b1;
            d = 8'(who * 64 + k);
            if (who == 0) src_data0 = d; else src_data1 = d;
            if (src_valid[who] && src_ready[who]) begin
                exp_q.push_back(d);
                k++;
            end
            tick();
            cyc++;
        end
        src_valid = 2'b00;
        tests_run++;
        if (k != ((stop_at < n) ? stop_at : n)) begin
            failures++;
            $display("FAIL load_bytes: accepted=%0d expected=%0d", k, n);
        end
        if (stop_at >= n) begin
            tests_run++;
            if (state_dbg !== DRAIN || src_ready !== 2'b00) begin
                failures++;
                $display("FAIL enter_drain: state=%0d src_ready=%b expected state=%0d ready=00",
                         state_dbg, src_ready, DRAIN);
            end
            if (drain) begin
                il_out_valid = 1'b1;
                for (int j = 0; j < n; j++) tick();
                il_out_valid = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; req = 2'b00; len0 = '0; len1 = '0;
        src_data0 = '0; src_data1 = '0; src_valid = 2'b00; il_out_valid = 1'b0;
        model_rr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if ({grant, src_ready, il_valid, frame_done, len_err, timeout, busy} !== 10'b0) begin
            failures++;
            $display("FAIL reset_ctrl: grant=%b ready=%b valid=%b done=%b err=%b to=%b busy=%b expected all 0",
                     grant, src_ready, il_valid, frame_done, len_err, timeout, busy);
        end
        tests_run++;
        if (il_length !== 12'd0 || il_data !== 8'd0 || state_dbg !== IDLE) begin
            failures++;
            $display("FAIL reset_data: il_length=%0d il_data=%h state=%0d expected 0/00/IDLE",
                     il_length, il_data, state_dbg);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single_frame();
        clear_stats();
        len0 = 12'd16; req = 2'b01;
        run_frame(0, 16, 1'b0, 1'b1, 1'b0, 999);
        model_rr = ~model_rr;
        tick();
        tests_run++;
        if (n_il_valid != 16) begin
            failures++; $display("FAIL single_il_valid: count=%0d expected=16", n_il_valid);
        end
        tests_run++;
        if (n_done_cyc != 1 || last_done !== 2'b01) begin
            failures++; $display("FAIL single_done: cycles=%0d value=%b expected 1/01", n_done_cyc, last_done);
        end
        tests_run++;
        if (grant !== 2'b00 || busy !== 1'b0) begin
            failures++; $display("FAIL single_release: grant=%b busy=%b expected 00/0", grant, busy);
        end
    endtask

    task automatic test_round_robin();
        int who;
        len0 = 12'd8; len1 = 12'd8; req = 2'b11;
        for (int f = 0; f < 4; f++) begin
            clear_stats();
            who = int'(model_rr);
            run_frame(who, 8, 1'b0, 1'b1, 1'b1, 999);
            model_rr = ~model_rr;
            if (f == 3) req = 2'b00;
            tests_run++;
            if (n_done_cyc != 1 || last_done !== 2'(1 << who)) begin
                failures++;
                $display("FAIL rr_done: frame=%0d done=%b cycles=%0d expected=%b", f, last_done,
                         n_done_cyc, 2'(1 << who));
            end
        end
        tick(); tick();
        tests_run++;
        if (grant !== 2'b00 || busy !== 1'b0) begin
            failures++; $display("FAIL rr_idle: grant=%b busy=%b expected 00/0", grant, busy);
        end
    endtask

    task automatic test_len_err();
        logic [11:0] bad [3];
        int b;
        int who;
        bad[0] = 12'd12; bad[1] = 12'd0; bad[2] = 12'd2720;
        for (int t = 0; t < 3; t++) begin
            clear_stats();
            len1 = bad[t]; req = 2'b10;
            b = 0;
            while (n_err_cyc == 0 && b < 10) begin tick(); b++; end
            req = 2'b00;
            tick(); tick(); tick();
            model_rr = ~model_rr;
            tests_run++;
            if (n_err_cyc != 1 || last_err !== 2'b10 || grant_or !== 2'b00) begin
                failures++;
                $display("FAIL len_err: len=%0d err=%b cycles=%0d grants_seen=%b expected 10/1/00",
                         bad[t], last_err, n_err_cyc, grant_or);
            end
        end
        // Pointer must have moved once per rejection.
        clear_stats();
        len0 = 12'd8; len1 = 12'd8; req = 2'b11;
        who = int'(model_rr);
        run_frame(who, 8, 1'b0, 1'b1, 1'b1, 999);
        req = 2'b00;
        model_rr = ~model_rr;
        tests_run++;
        if (last_done !== 2'(1 << who)) begin
            failures++; $display("FAIL len_err_rr: done=%b expected=%b", last_done, 2'(1 << who));
        end
    endtask

    task automatic test_gappy_load();
        clear_stats();
        len0 = 12'd24; req = 2'b01;
        run_frame(0, 24, 1'b1, 1'b1, 1'b0, 999);
        model_rr = ~model_rr;
        tick();
        tests_run++;
        if (n_il_valid != 24 || last_done !== 2'b01) begin
            failures++;
            $display("FAIL gappy: il_valid=%0d done=%b expected 24/01", n_il_valid, last_done);
        end
    endtask

    task automatic test_timeout();
        int c;
        clear_stats();
        len0 = 12'd8; req = 2'b01;
        run_frame(0, 8, 1'b0, 1'b0, 1'b0, 999);
        c = 0;
        while (n_to_cyc == 0 && c < 40) begin tick(); c++; end
        model_rr = ~model_rr;
        tests_run++;
        if (c != 20) begin
            failures++; $display("FAIL timeout_cycles: idle_cycles=%0d expected=20", c);
        end
        tests_run++;
        if (grant !== 2'b00 || n_done_cyc != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL timeout_release: grant=%b done_cycles=%0d busy=%b expected 00/0/0",
                     grant, n_done_cyc, busy);
        end
        clear_stats();
        req = 2'b01;
        run_frame(0, 8, 1'b0, 1'b1, 1'b0, 999);
        model_rr = ~model_rr;
        tests_run++;
        if (last_done !== 2'b01) begin
            failures++; $display("FAIL timeout_next: done=%b expected=01", last_done);
        end
    endtask

    task automatic test_reset_mid_load();
        clear_stats();
        len0 = 12'd16; req = 2'b01;
        run_frame(0, 16, 1'b0, 1'b0, 1'b0, 5);
        reset = 1'b1;
        #1;
        tests_run++;
        if ({grant, src_ready, il_valid, busy, frame_done, timeout} !== 8'b0 ||
            il_length !== 12'd0 || state_dbg !== IDLE) begin
            failures++;
            $display("FAIL mid_reset: grant=%b ready=%b valid=%b busy=%b len=%0d state=%0d expected all 0",
                     grant, src_ready, il_valid, busy, il_length, state_dbg);
        end
        exp_q.delete();
        model_rr = 1'b0;
        tick();
        reset = 1'b0;
        clear_stats();
        len0 = 12'd8; req = 2'b01;
        run_frame(0, 8, 1'b0, 1'b1, 1'b0, 999);
        model_rr = ~model_rr;
        tests_run++;
        if (last_done !== 2'b01 || n_il_valid != 8) begin
            failures++;
            $display("FAIL post_reset: done=%b il_valid=%0d expected 01/8", last_done, n_il_valid);
        end
        // After one frame since reset, requester 1 wins the tie.
        clear_stats();
        len1 = 12'd8; req = 2'b11;
        run_frame(int'(model_rr), 8, 1'b0, 1'b1, 1'b1, 999);
        req = 2'b00;
        tests_run++;
        if (last_done !== 2'b10) begin
            failures++; $display("FAIL post_reset_rr: done=%b expected=10", last_done);
        end
        model_rr = ~model_rr;
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_round_robin();
        test_len_err();
        test_gappy_load();
        test_timeout();
        test_reset_mid_load();
        tick(); tick();
        tests_run++;
        if (exp_q.size() != 0) begin
            failures++; $display("FAIL sb_leftover: %0d bytes never seen, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
